// File: rtl/vga_sprite_pipe.sv
`default_nettype none
// ============================================================================
// Module   : vga_sprite_pipe
// Purpose  : Overlays one ROM-backed sprite on a VGA pixel stream.
//            The sprite position is sampled once per frame at (hc,vc)=(0,0).
//            The sprite can be zoomed by 2^SCALE in both axes. ROM addresses
//            come from per-line counters rather than a multiplier. The
//            window flag, blank and background colour are delayed so they
//            line up with the ROM data. Total latency from hc/vc/bg_rgb to
//            R/G/B/hit is ROM_LAT+2 cycles.
// Ports    : clk, rst (async, active-high)
//            en               - sprite enable
//            hc, vc           - current pixel coordinates
//            blank            - pixel outside active area
//            pos_x, pos_y     - requested sprite top-left corner
//            bg_rgb           - background colour {R3,G3,B2}
//            mem_value        - ROM data, ROM_LAT cycles after rom_addr
//            rom_addr         - registered ROM address
//            R, G, B, hit     - registered output colour / opaque-texel flag
// Revision : 1.0 - initial release
// ============================================================================
module vga_sprite_pipe #(
  parameter int          IMG_W   = 32,
  parameter int          IMG_H   = 32,
  parameter int          ADDR_W  = 15,
  parameter int          ROM_LAT = 1,
  parameter int          SCALE   = 0,
  parameter logic [7:0]  TRANSP  = 8'hE3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [10:0]       hc,
  input  logic [10:0]       vc,
  input  logic              blank,
  input  logic [10:0]       pos_x,
  input  logic [10:0]       pos_y,
  input  logic [7:0]        bg_rgb,
  input  logic [7:0]        mem_value,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [2:0]        R,
  output logic [2:0]        G,
  output logic [1:0]        B,
  output logic              hit
);

  localparam int              DLY   = 1 + ROM_LAT;
  localparam int              SL_W  = (SCALE > 0) ? SCALE : 1;
  localparam logic [11:0]     SW    = 12'(IMG_W << SCALE);
  localparam logic [11:0]     SH    = 12'(IMG_H << SCALE);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W);

  // Latched frame position
  logic [10:0] x_l;
  logic [10:0] y_l;
  logic        pos_valid;

  // Line counters
  logic [ADDR_W-1:0] row_base;
  logic [SL_W-1:0]   sub_line;
  logic [ADDR_W-1:0] row_base_nxt;
  logic [SL_W-1:0]   sub_line_nxt;
  logic [SL_W-1:0]   sub_inc;
  logic              sub_wrap;

  // In the latch cycle the freshly requested position already governs the
  // window and the row counters, so a sprite at y=0 starts on line 0.
  logic        latch;
  logic [10:0] x_eff;
  logic [10:0] y_eff;
  logic        pv_eff;

  logic [11:0] hc12, vc12, x_lo, x_hi, y_lo, y_hi;
  logic        in_win;
  logic [10:0] dx;
  logic [10:0] col;

  // Alignment shift registers
  logic [DLY-1:0] win_sr;
  logic [DLY-1:0] blank_sr;
  logic [7:0]     bg_sr [DLY];

  assign latch  = (hc == 11'd0) && (vc == 11'd0);
  assign x_eff  = latch ? pos_x : x_l;
  assign y_eff  = latch ? pos_y : y_l;
  assign pv_eff = latch | pos_valid;

  // 12-bit compares keep a window crossing 2047 from wrapping to zero.
  assign hc12 = {1'b0, hc};
  assign vc12 = {1'b0, vc};
  assign x_lo = {1'b0, x_eff};
  assign y_lo = {1'b0, y_eff};
  assign x_hi = x_lo + SW;
  assign y_hi = y_lo + SH;

  assign in_win = pv_eff & en &
                  (hc12 >= x_lo) & (hc12 < x_hi) &
                  (vc12 >= y_lo) & (vc12 < y_hi);

  // Sub-line counter: with no zoom every sprite line advances the row.
  generate
    if (SCALE == 0) begin : g_noscale
      assign sub_inc  = '0;
      assign sub_wrap = 1'b1;
    end else begin : g_scale
      assign sub_inc  = sub_line + SL_W'(1);
      assign sub_wrap = (sub_inc == '0);
    end
  endgenerate

  always_comb begin
    row_base_nxt = row_base;
    sub_line_nxt = sub_line;
    if (hc == 11'd0) begin
      if (vc12 == y_lo) begin
        row_base_nxt = '0;
        sub_line_nxt = '0;
      end else if ((vc12 > y_lo) && (vc12 < y_hi)) begin
        sub_line_nxt = sub_inc;
        if (sub_wrap) begin
          row_base_nxt = row_base + ROW_STEP;
        end
      end
    end
  end

  // The address uses the next row_base so the first pixel of a line (hc==0)
  // already sees that line's row.
  assign dx  = hc - x_eff;
  assign col = dx >> SCALE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_l       <= '0;
      y_l       <= '0;
      pos_valid <= 1'b0;
      row_base  <= '0;
      sub_line  <= '0;
      rom_addr  <= '0;
    end else begin
      if (latch) begin
        x_l       <= pos_x;
        y_l       <= pos_y;
        pos_valid <= 1'b1;
      end
      row_base <= row_base_nxt;
      sub_line <= sub_line_nxt;
      rom_addr <= in_win ? (row_base_nxt + ADDR_W'(col)) : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_sr   <= '0;
      blank_sr <= '0;
      for (int i = 0; i < DLY; i++) begin
        bg_sr[i] <= '0;
      end
    end else begin
      win_sr   <= {win_sr[DLY-2:0], in_win};
      blank_sr <= {blank_sr[DLY-2:0], blank};
      bg_sr[0] <= bg_rgb;
      for (int i = 1; i < DLY; i++) begin
        bg_sr[i] <= bg_sr[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {R, G, B} <= 8'h00;
      hit       <= 1'b0;
    end else if (blank_sr[DLY-1]) begin
      {R, G, B} <= 8'h00;
      hit       <= 1'b0;
    end else if (win_sr[DLY-1] && (mem_value != TRANSP)) begin
      {R, G, B} <= mem_value;
      hit       <= 1'b1;
    end else begin
      {R, G, B} <= bg_sr[DLY-1];
      hit       <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vga_sprite_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_sprite_pipe
// Purpose  : Scoreboard bench for vga_sprite_pipe. Two instances share one
//            pixel stream: dut0 uses the defaults, and dut1 uses SCALE=1 and
//            ROM_LAT=3. Expected addresses and pixels come from a
//            texel-coordinate reference model. A negedge monitor pops and
//            compares them when they fall due.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_sprite_pipe;

  localparam int H_TOT = 120;
  localparam int HA    = 112;
  localparam int V_TOT = 72;
  localparam int VA    = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b1;
  logic [10:0] hc = '0, vc = '0, pos_x = '0, pos_y = '0;
  logic        blank = 1'b0;
  logic [7:0]  bg_rgb = '0;

  logic [14:0] addr0, addr1;
  logic [2:0]  r0, g0, r1, g1;
  logic [1:0]  b0, b1;
  logic        hit0, hit1;
  logic [7:0]  mem0;
  logic [7:0]  p1 [3];

  logic [7:0]  rom [1024];

  typedef struct { int due; logic [14:0] addr; } addr_t;
  typedef struct { int due; logic [7:0] rgb; logic hit; } pix_t;
  addr_t qa [2][$];
  pix_t  qp [2][$];

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  int rst_cnt = 0;

  // Reference-model frame state
  int ml_x = 0, ml_y = 0;
  bit ml_pv = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ROM models, ROM_LAT 1 and 3
  always @(posedge clk) mem0 <= rom[addr0[9:0]];
  always @(posedge clk) begin
    p1[0] <= rom[addr1[9:0]];
    p1[1] <= p1[0];
    p1[2] <= p1[1];
  end

  vga_sprite_pipe u_dut0 (
    .clk(clk), .rst(rst), .en(en), .hc(hc), .vc(vc), .blank(blank),
    .pos_x(pos_x), .pos_y(pos_y), .bg_rgb(bg_rgb), .mem_value(mem0),
    .rom_addr(addr0), .R(r0), .G(g0), .B(b0), .hit(hit0)
  );

  vga_sprite_pipe #(.SCALE(1), .ROM_LAT(3)) u_dut1 (
    .clk(clk), .rst(rst), .en(en), .hc(hc), .vc(vc), .blank(blank),
    .pos_x(pos_x), .pos_y(pos_y), .bg_rgb(bg_rgb), .mem_value(p1[2]),
    .rom_addr(addr1), .R(r1), .G(g1), .B(b1), .hit(hit1)
  );

  // Sprite texel lookup in image coordinates: texel (tx,ty) = pixel offset
  // divided by the zoom factor, stored row-major with 32 texels per row.
  function automatic void model(input int s, input int h, input int v,
                                input bit bl, input bit e, input logic [7:0] bg,
                                output logic [14:0] addr, output logic [7:0] rgb,
                                output logic ht);
    int zoom, tx, ty, a;
    bit w;
    logic [7:0] dt;
    zoom = 1 << s;
    w = ml_pv && e && (h >= ml_x) && (h < ml_x + 32 * zoom) &&
        (v >= ml_y) && (v < ml_y + 32 * zoom);
    a = 0;
    if (w) begin
      tx = (h - ml_x) / zoom;
      ty = (v - ml_y) / zoom;
      a  = ty * 32 + tx;
    end
    addr = 15'(a);
    dt   = rom[a];
    ht   = !bl && w && (dt != 8'hE3);
    rgb  = bl ? 8'h00 : (ht ? dt : bg);
  endfunction

  task automatic pix(input int h, input int v, input bit bl, input bit e);
    logic [14:0] a;
    logic [7:0]  c;
    logic        ht;
    @(posedge clk);
    #1;
    hc     = 11'(h);
    vc     = 11'(v);
    blank  = bl;
    en     = e;
    bg_rgb = 8'($urandom);
    if (rst_cnt > 0) begin
      rst = 1'b1;
      rst_cnt--;
      ml_pv = 1'b0;
      ml_x  = 0;
      ml_y  = 0;
      for (int d = 0; d < 2; d++) begin
        qa[d].delete();
        qp[d].delete();
      end
      return;
    end
    rst = 1'b0;
    if (h == 0 && v == 0) begin
      ml_x  = int'(pos_x);
      ml_y  = int'(pos_y);
      ml_pv = 1'b1;
    end
    for (int d = 0; d < 2; d++) begin
      model(d, h, v, bl, e, bg_rgb, a, c, ht);
      qa[d].push_back('{cyc + 1, a});
      qp[d].push_back('{cyc + (d == 1 ? 3 : 1) + 2, c, ht});
    end
  endtask

  // px < 0 keeps the current pos_x/pos_y. wide scans hc = 0 then 1990..2047.
  task automatic frame(input int v0, input int px, input int py, input bit wide,
                       input bit en_rand, input int chg_v, input int rst_v,
                       input int rst_h);
    int nh, h;
    bit bl, e;
    if (px >= 0) begin
      pos_x = 11'(px);
      pos_y = 11'(py);
    end
    nh = wide ? 59 : H_TOT;
    for (int v = v0; v < V_TOT; v++) begin
      for (int i = 0; i < nh; i++) begin
        h  = wide ? ((i == 0) ? 0 : 1989 + i) : i;
        bl = wide ? 1'b0 : ((h >= HA) || (v >= VA));
        e  = en_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (v == chg_v && i == 0) begin
          pos_x = 11'($urandom_range(0, 100));
          pos_y = 11'($urandom_range(0, 60));
        end
        if (v == rst_v && h == rst_h) rst_cnt = 3;
        pix(h, v, bl, e);
      end
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      logic [14:0] a;
      logic [7:0]  c;
      logic        ht;
      addr_t       ea;
      pix_t        ep;
      a  = (d == 1) ? addr1 : addr0;
      c  = (d == 1) ? {r1, g1, b1} : {r0, g0, b0};
      ht = (d == 1) ? hit1 : hit0;
      if (rst) begin
        n_cmp++;
        if (a != '0 || c != 8'h00 || ht != 1'b0) begin
          n_bad++;
          $display("FAIL reset_zero dut%0d cyc %0d: addr=%0d rgb=%h hit=%b, expected 0/00/0",
                   d, cyc, a, c, ht);
        end
      end else begin
        while (qa[d].size() > 0 && qa[d][0].due <= cyc) begin
          ea = qa[d].pop_front();
          n_cmp++;
          if (ea.due != cyc || a != ea.addr) begin
            n_bad++;
            $display("FAIL rom_addr dut%0d cyc %0d (due %0d): got %0d expected %0d",
                     d, cyc, ea.due, a, ea.addr);
          end
        end
        while (qp[d].size() > 0 && qp[d][0].due <= cyc) begin
          ep = qp[d].pop_front();
          n_cmp++;
          if (ep.due != cyc || c != ep.rgb || ht != ep.hit) begin
            n_bad++;
            $display("FAIL pixel dut%0d cyc %0d (due %0d): got rgb=%h hit=%b expected rgb=%h hit=%b",
                     d, cyc, ep.due, c, ht, ep.rgb, ep.hit);
          end
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 1024; i++) begin
      rom[i] = ($urandom_range(0, 5) == 0) ? 8'hE3 : 8'($urandom);
    end
    pos_x = 11'd60;
    pos_y = 11'd45;
    repeat (3) @(posedge clk);
    // Partial frame after reset: enabled, but nothing latched yet
    frame(40, -1, 0, 1'b0, 1'b0, -1, -1, -1);
    // Partly blanked sprite at the right edge
    frame(0, 100, 50, 1'b0, 1'b0, -1, -1, -1);
    // Sprite at the origin
    frame(0, 0, 0, 1'b0, 1'b0, -1, -1, -1);
    // Position changes mid-frame, then takes effect on the next frame
    frame(0, 30, 20, 1'b0, 1'b0, 30, -1, -1);
    frame(0, -1, 0, 1'b0, 1'b1, -1, -1, -1);
    // Window close to and beyond hc=2047
    frame(0, 2000, 5, 1'b1, 1'b0, -1, -1, -1);
    // Reset pulse inside the sprite, then recovery on the next frame
    frame(0, 20, 10, 1'b0, 1'b0, -1, 20, 30);
    frame(0, $urandom_range(0, 90), $urandom_range(0, 50), 1'b0, 1'b0, -1, -1, -1);
    repeat (8) @(posedge clk);
    @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (qa[d].size() != 0 || qp[d].size() != 0) begin
        n_bad++;
        $display("FAIL drain dut%0d: %0d/%0d entries left, expected 0/0",
                 d, qa[d].size(), qp[d].size());
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
